fp32_adder_seq: RTL and testbench

FP32_ADDER_SEQ -- requirements
Module: fp32_adder_seq

---
 rtl/fp32_adder_seq_pkg.sv | 18 +
 rtl/fp32_adder_seq_lzc.sv | 15 +
 rtl/fp32_adder_seq.sv | 157 +++++++++++++++
 tb/tb_fp32_adder_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fp32_adder_seq_pkg.sv
// Shared state encoding and binary32 constants for the sequential FP32 adder.
package fp32_adder_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  localparam int          FP32_EXP_BIAS  = 127;
  localparam int          FP32_EXP_MAX   = 255;
  localparam logic [31:0] FP32_QNAN      = 32'h7FC00000;
  localparam int          FP32_ALIGN_CAP = 27;

endpackage

// File: rtl/fp32_adder_seq_lzc.sv
// Leading-zero counter over the 28-bit pre-normalisation sum (28 when all zero).
module fp32_lzc (
  input  logic [27:0] d,
  output logic [4:0]  cnt
);

  // Later (higher) indices override, so the most significant set bit wins.
  always_comb begin
    cnt = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (d[i]) cnt = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp32_adder_seq.sv
// Multi-cycle binary32 adder: IDLE→ALIGN→ADD→NORM→ROUND→DONE, RNE rounding, flush-to-zero.
module fp32_adder_seq
  import fp32_adder_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  state_t state_reg, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);

  // Unpack: denormals become zero significands; specials resolved up front.
  logic        a_nan, b_nan, a_inf, b_inf, special_in;
  logic [31:0] special_val_in;
  logic [23:0] a_sig, b_sig;

  always_comb begin
    a_nan      = (&a[30:23]) & (|a[22:0]);
    b_nan      = (&b[30:23]) & (|b[22:0]);
    a_inf      = (&a[30:23]) & ~(|a[22:0]);
    b_inf      = (&b[30:23]) & ~(|b[22:0]);
    a_sig      = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    b_sig      = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    special_in = a_nan | b_nan | a_inf | b_inf;
    if (a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31]))) special_val_in = FP32_QNAN;
    else if (a_inf)                                        special_val_in = {a[31], 8'hFF, 23'd0};
    else                                                   special_val_in = {b[31], 8'hFF, 23'd0};
  end

  logic               sa_reg, sb_reg, special_reg;
  logic [7:0]         ea_reg, eb_reg;
  logic [23:0]        ma_reg, mb_reg;
  logic [31:0]        special_val_reg;
  logic               sign_big_reg, sign_small_reg, sign_reg, zero_reg;
  logic [7:0]         big_e_reg;
  logic [26:0]        big_x_reg, small_x_reg, m_reg;
  logic [27:0]        sum_reg;
  logic signed [9:0]  e_reg;
  logic [31:0]        result_reg;

  // Alignment: larger magnitude first, smaller shifted right with sticky collapse.
  logic        a_big, big_s, small_s;
  logic [7:0]  big_e, small_e, diff;
  logic [23:0] big_m, small_m;
  logic [4:0]  sh;
  logic [53:0] wide;
  logic [26:0] small_aligned;

  always_comb begin
    a_big   = {ea_reg, ma_reg} >= {eb_reg, mb_reg};
    big_s   = a_big ? sa_reg : sb_reg;
    small_s = a_big ? sb_reg : sa_reg;
    big_e   = a_big ? ea_reg : eb_reg;
    small_e = a_big ? eb_reg : ea_reg;
    big_m   = a_big ? ma_reg : mb_reg;
    small_m = a_big ? mb_reg : ma_reg;
    diff    = big_e - small_e;
    sh      = (diff > 8'(FP32_ALIGN_CAP)) ? 5'(FP32_ALIGN_CAP) : diff[4:0];
    wide    = {small_m, 3'b000, 27'd0} >> sh;
    small_aligned = {wide[53:28], wide[27] | (|wide[26:0])};
  end

  logic [4:0] lz, lz_m1;
  fp32_lzc u_lzc (.d(sum_reg), .cnt(lz));
  assign lz_m1 = lz - 5'd1;

  // Round: m_reg[26:3] significand, [2] guard, [1] round, [0] sticky.
  logic              round_up;
  logic [24:0]       rsig;
  logic signed [9:0] rexp;
  logic [22:0]       frac;
  logic [31:0]       packed_res;

  always_comb begin
    round_up = m_reg[2] & (m_reg[1] | m_reg[0] | m_reg[3]);
    rsig     = {1'b0, m_reg[26:3]} + 25'(round_up);
    rexp     = e_reg + $signed({9'd0, rsig[24]});
    frac     = rsig[24] ? rsig[23:1] : rsig[22:0];
    if (special_reg)                          packed_res = special_val_reg;
    else if (zero_reg || rexp <= 10'sd0)      packed_res = {sign_reg, 31'd0};
    else if (rexp >= 10'(FP32_EXP_MAX))       packed_res = {sign_reg, 8'hFF, 23'd0};
    else                                      packed_res = {sign_reg, rexp[7:0], frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_reg <= 1'b0; sb_reg <= 1'b0; ea_reg <= '0; eb_reg <= '0;
      ma_reg <= '0; mb_reg <= '0; special_reg <= 1'b0; special_val_reg <= '0;
      sign_big_reg <= 1'b0; sign_small_reg <= 1'b0; big_e_reg <= '0;
      big_x_reg <= '0; small_x_reg <= '0; sum_reg <= '0;
      sign_reg <= 1'b0; zero_reg <= 1'b0; m_reg <= '0; e_reg <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          sa_reg <= a[31]; ea_reg <= a[30:23]; ma_reg <= a_sig;
          sb_reg <= b[31]; eb_reg <= b[30:23]; mb_reg <= b_sig;
          special_reg <= special_in; special_val_reg <= special_val_in;
        end
        ALIGN: begin
          sign_big_reg <= big_s; sign_small_reg <= small_s; big_e_reg <= big_e;
          big_x_reg <= {big_m, 3'b000}; small_x_reg <= small_aligned;
        end
        ADD: begin
          logic [27:0] s;
          s = (sign_big_reg == sign_small_reg) ? {1'b0, big_x_reg} + {1'b0, small_x_reg}
                                               : {1'b0, big_x_reg} - {1'b0, small_x_reg};
          sum_reg  <= s;
          zero_reg <= (s == 28'd0);
          // Exact cancellation gives +0; only -0 + -0 keeps the minus sign.
          sign_reg <= (s == 28'd0) ? (sign_big_reg & sign_small_reg) : sign_big_reg;
        end
        NORM: begin
          if (sum_reg[27]) begin
            m_reg <= {sum_reg[27:2], sum_reg[1] | sum_reg[0]};
            e_reg <= $signed({2'b00, big_e_reg}) + 10'sd1;
          end else begin
            m_reg <= sum_reg[26:0] << lz_m1;
            e_reg <= $signed({2'b00, big_e_reg}) - $signed({5'd0, lz_m1});
          end
        end
        ROUND: result_reg <= packed_res;
        default: ;
      endcase
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_fp32_adder_seq.sv
// Self-checking bench: exact-integer reference model, directed vectors, latency/backpressure/reset checks.
module tb_fp32_adder_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid;
  logic [31:0] result;

  fp32_adder_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .result(result), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: exact integer sum of the two significands, then one RNE rounding.
  function automatic logic [31:0] model_add(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, eb, es, d, p, e, sh;
    logic sx, sy, sb, ss;
    logic [23:0] mx, my, mb, ms;
    logic [79:0] s, keep, rem, half;
    sx = x[31]; sy = y[31];
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return 32'h7FC00000;
    if (ex == 255 && ey == 255) return (sx == sy) ? x : 32'h7FC00000;
    if (ex == 255) return x;
    if (ey == 255) return y;
    mx = (ex == 0) ? 24'd0 : {1'b1, x[22:0]};
    my = (ey == 0) ? 24'd0 : {1'b1, y[22:0]};
    if (ex == 0) ex = 0;
    if (ey == 0) ey = 0;
    if ((longint'(ex) * 33554432 + longint'(mx)) >= (longint'(ey) * 33554432 + longint'(my))) begin
      sb = sx; eb = ex; mb = mx; ss = sy; es = ey; ms = my;
    end else begin
      sb = sy; eb = ey; mb = my; ss = sx; es = ex; ms = mx;
    end
    if (mb == 0) return {sb & ss, 31'd0};
    d = eb - es;
    if (ms == 0 || d > 40) return {sb, 8'(eb), mb[22:0]};
    s = (80'(mb) << d);
    s = (sb == ss) ? s + 80'(ms) : s - 80'(ms);
    if (s == 0) return 32'h00000000;
    p = 0;
    for (int i = 0; i < 80; i++) if (s[i]) p = i;
    if (p > 23) begin
      sh   = p - 23;
      keep = s >> sh;
      rem  = s & ((80'd1 << sh) - 80'd1);
      half = 80'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 80'd1;
      if (keep[24]) begin keep = keep >> 1; sh = sh + 1; end
      e = es + sh;
    end else begin
      keep = s << (23 - p);
      e = es - (23 - p);
    end
    if (e <= 0) return {sb, 31'd0};
    if (e >= 255) return {sb, 8'hFF, 23'd0};
    return {sb, 8'(e), keep[22:0]};
  endfunction

  // Compare process: result checked against the model every cycle out_valid is high.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out_valid actual=1 required=0");
      end else begin
        chk("result", result, exp_q[0]);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  // One operation; called at a negedge with the DUT idle.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] lit, input bit has_lit, input int hold);
    logic [31:0] m, held;
    m = model_add(x, y);
    if (has_lit) chk("model_vs_literal", m, lit);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(m);
    a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("latency_edge%0d", k), {31'd0, out_valid}, (k == 4) ? 32'd1 : 32'd0);
    end
    held = result;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result_stable", result, held);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_take_out_valid", {31'd0, out_valid}, 32'd0);
    chk("after_take_in_ready", {31'd0, in_ready}, 32'd1);
    $display("op a=%h b=%h expected=%h", x, y, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_result", result, 32'h0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    run_op(32'h40B00000, 32'h40100000, 32'h40F80000, 1, 0);  // 5.5 + 2.25
    run_op(32'h40800000, 32'hC0C00000, 32'hC0000000, 1, 0);  // 4 + -6
    run_op(32'h3F800000, 32'hBF800000, 32'h00000000, 1, 0);  // exact cancel
    run_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, 1, 0);  // inf - inf
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1, 0);  // overflow
    run_op(32'h00000001, 32'h3F800000, 32'h3F800000, 1, 0);  // denormal as zero
    run_op(32'h3F800000, 32'h33800000, 32'h3F800000, 1, 0);  // tie, even kept
    run_op(32'h3F800001, 32'h33800000, 32'h3F800002, 1, 0);  // tie, round up
    run_op(32'h80000000, 32'h80000000, 32'h80000000, 1, 0);  // -0 + -0
    run_op(32'h3F800000, 32'hB3800000, 32'h3F7FFFFF, 1, 0);  // 1 - 2^-24
    run_op(32'h7FA00000, 32'h3F800000, 32'h7FC00000, 1, 0);  // NaN in
    run_op(32'hFF800000, 32'h42000000, 32'hFF800000, 1, 0);  // -inf + finite
    run_op(32'h3FC00000, 32'h3FC00000, 32'h40400000, 1, 10); // 1.5+1.5 with backpressure

    // Reset while the operation sits in NORM.
    exp_q.push_back(model_add(32'h40400000, 32'h40000000));
    a = 32'h40400000; b = 32'h40000000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midop_reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midop_reset_result", result, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(32'h41200000, 32'h40400000, 32'h41500000, 1, 0);  // 10 + 3

    for (int n = 0; n < 20; n++) begin
      logic [31:0] rx, ry;
      rx = {1'($urandom), 8'(100 + ($urandom % 50)), 23'($urandom)};
      ry = {1'($urandom), 8'(100 + ($urandom % 50)), 23'($urandom)};
      run_op(rx, ry, 32'h0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
